// File: rtl/ps2_key_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_key_rx_pkg;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_FERR = 3;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_PAR_BIT   = 9;
  localparam int FRAME_STOP_BIT  = 10;

  // f = {stop, parity, data[7:0]}; data plus parity must be odd, stop high
  function automatic logic frame_ok(input logic [9:0] f);
    return (^f[8:0]) & f[9];
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Core-side bus of the PS/2 receiver: pop/clear strobes in, data/status/irq out.
interface ps2_key_rx_if;
  logic       rd;
  logic       clr;
  logic [7:0] key_data;
  logic [7:0] key_status;
  logic       key_int;

  modport master (output rd, clr, input key_data, key_status, key_int);
  modport slave  (input rd, clr, output key_data, key_status, key_int);
endinterface

// File: rtl/ps2_key_rx_fifo.sv
// Scan-code FIFO; a push into a full FIFO is only accepted alongside a pop.
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchroniser, frame FSM, scan-code FIFO, irq.
// Optional: define PS2_KEY_RX_BREAK_FILTER_EN to drop break codes (F0 xx).
module ps2_key_rx
  import ps2_key_rx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_key_rx_if.slave   bus
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, s_clk, s_dat, fall;
  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [TW-1:0]          to_cnt;
  logic [9:0]             shreg;
  logic                   ferr, ovf, key_int_r, skip;
  logic                   frame_valid, filt_drop, push_req, push_ok, ovf_evt, ferr_evt, timeout;
  logic [7:0]             head;
  logic                   full, empty;

  assign s_clk = clk_sync[SYNC_STAGES-1];
  assign s_dat = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~s_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync[0] <= ps2_clk;
      dat_sync[0] <= ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i] <= clk_sync[i-1];
        dat_sync[i] <= dat_sync[i-1];
      end
      clk_prev <= s_clk;
    end
  end

  assign frame_valid = frame_ok(shreg);
`ifdef PS2_KEY_RX_BREAK_FILTER_EN
  assign filt_drop = skip | (shreg[7:0] == PS2_BREAK);
`else
  assign filt_drop = 1'b0;
`endif
  assign push_req = (state == CHECK) & frame_valid & ~filt_drop;
  // a full FIFO still takes the byte when the core pops in the same cycle
  assign push_ok  = push_req & (~full | (bus.rd & ~empty));
  assign ovf_evt  = push_req & ~push_ok;
  assign timeout  = (state == RECV) & ~fall & (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign ferr_evt = ((state == CHECK) & ~frame_valid) | timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      shreg     <= '0;
      ferr      <= 1'b0;
      ovf       <= 1'b0;
      key_int_r <= 1'b0;
      skip      <= 1'b0;
    end else begin
      key_int_r <= push_ok;
      if (ovf_evt)      ovf  <= 1'b1;
      else if (bus.clr) ovf  <= 1'b0;
      if (ferr_evt)     ferr <= 1'b1;
      else if (bus.clr) ferr <= 1'b0;

      case (state)
        IDLE: if (fall && !s_dat) begin
          state   <= RECV;
          bit_cnt <= 4'd1;
          to_cnt  <= '0;
        end
        RECV: if (fall) begin
          shreg  <= {s_dat, shreg[9:1]};
          to_cnt <= '0;
          if (bit_cnt == 4'(FRAME_STOP_BIT)) state <= CHECK;
          else                               bit_cnt <= bit_cnt + 4'd1;
        end else if (timeout) begin
          state <= IDLE;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
        CHECK: begin
          state <= IDLE;
`ifdef PS2_KEY_RX_BREAK_FILTER_EN
          if (frame_valid) skip <= skip ? 1'b0 : (shreg[7:0] == PS2_BREAK);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (bus.rd),
    .din   (shreg[7:0]),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.key_data   = empty ? 8'h00 : head;
  assign bus.key_status = {4'b0, ferr, ovf, full, ~empty};
  assign bus.key_int    = key_int_r;

endmodule
